ddr2_arbiter: RTL and testbench

- Shares the single DDR2 line port (27-bit byte address, 128-bit line, `ddr2_enable`/`ddr2_read`/`ddr2_available` handshake) between two line-level requesters, e.g. instruction cache (port 0) and data cache (port 1).
- Round-robin arbitration; one DDR2 transaction in flight at a time.
- Sits between the caches and the DDR2 controller/model.

---
 rtl/ddr2_arbiter_pkg.sv | 25 ++
 rtl/ddr2_arbiter_if.sv | 45 ++++
 rtl/ddr2_arbiter.sv | 97 +++++++++
 tb/tb_ddr2_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_arbiter_pkg.sv
// Shared types for the two-port DDR2 line arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ddr2_pkg;

    localparam int ADDR_W = 27;
    localparam int LINE_W = 128;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_RD = 3'd2,
        WAIT_WR = 3'd3,
        DONE    = 3'd4
    } arb_state_t;

    // DDR2 works on whole 16-byte lines, so the byte offset is dropped.
    function automatic addr_t line_base(addr_t a);
        return a & ~addr_t'(4'hF);
    endfunction

endpackage

// File: rtl/ddr2_arbiter_if.sv
// Requester-side and DDR2-side signals of the line arbiter, bundled.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until their done pulse; DDR2 paces reads via ddr2_available.
interface ddr2_arbiter_if;
    import ddr2_pkg::*;

    logic  req0;
    logic  req0_write;
    addr_t req0_addr;
    line_t req0_wdata;
    logic  req1;
    logic  req1_write;
    addr_t req1_addr;
    line_t req1_wdata;
    logic  done0;
    logic  done1;
    line_t rd_data;
    logic  busy;
    logic  grant_id;
    addr_t ddr2_addr;
    logic  ddr2_enable;
    logic  ddr2_read;
    line_t to_ddr2_data;
    line_t ddr2_data;
    logic  ddr2_available;

    // Arbiter side.
    modport slave (
        input  req0, req0_write, req0_addr, req0_wdata,
        input  req1, req1_write, req1_addr, req1_wdata,
        input  ddr2_data, ddr2_available,
        output done0, done1, rd_data, busy, grant_id,
        output ddr2_addr, ddr2_enable, ddr2_read, to_ddr2_data
    );

    // Environment side: the two caches plus the DDR2 controller.
    modport master (
        output req0, req0_write, req0_addr, req0_wdata,
        output req1, req1_write, req1_addr, req1_wdata,
        output ddr2_data, ddr2_available,
        input  done0, done1, rd_data, busy, grant_id,
        input  ddr2_addr, ddr2_enable, ddr2_read, to_ddr2_data
    );

endinterface

// File: rtl/ddr2_arbiter.sv
// Round-robin arbiter sharing one DDR2 line port between two requesters, one transaction at a time.
// Latency: req seen in IDLE at N -> ddr2_enable at N+1 -> done at N+3 (read, data ready) or N+2+WR_LAT (write).
// Backpressure: requests held while busy; reads stall indefinitely until ddr2_available.
module ddr2_arbiter
    import ddr2_pkg::*;
#(
    parameter int WR_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    ddr2_arbiter_if.slave bus
);

    localparam logic [3:0] WR_LAT_C = 4'(WR_LAT);

    arb_state_t state;
    logic       rr;
    logic       gid;
    logic       lat_rd;
    addr_t      lat_addr;
    line_t      lat_wdata;
    line_t      rd_q;
    logic [3:0] wr_cnt;

    logic       win;
    logic       win_write;
    addr_t      win_addr;
    line_t      win_wdata;

    // Pick the winner: a lone request wins outright, a tie goes to port rr.
    always_comb begin
        win       = (bus.req0 && bus.req1) ? rr : bus.req1;
        win_write = win ? bus.req1_write : bus.req0_write;
        win_addr  = win ? bus.req1_addr  : bus.req0_addr;
        win_wdata = win ? bus.req1_wdata : bus.req0_wdata;
    end

    // Transaction FSM; command fields are latched at grant so later input changes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= 1'b0;
            gid       <= 1'b0;
            lat_rd    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rd_q      <= '0;
            wr_cnt    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        gid       <= win;
                        lat_rd    <= ~win_write;
                        lat_addr  <= line_base(win_addr);
                        lat_wdata <= win_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wr_cnt <= 4'd1;
                    state  <= lat_rd ? WAIT_RD : WAIT_WR;
                end
                WAIT_RD: begin
                    if (bus.ddr2_available) begin
                        rd_q  <= bus.ddr2_data;
                        state <= DONE;
                    end
                end
                WAIT_WR: begin
                    if (wr_cnt == WR_LAT_C) begin
                        state <= DONE;
                    end else begin
                        wr_cnt <= wr_cnt + 4'd1;
                    end
                end
                DONE: begin
                    rr    <= ~gid;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset kills them immediately.
    assign bus.busy         = (state != IDLE);
    assign bus.ddr2_enable  = (state == ISSUE);
    assign bus.done0        = (state == DONE) && !gid;
    assign bus.done1        = (state == DONE) &&  gid;
    assign bus.grant_id     = gid;
    assign bus.ddr2_addr    = lat_addr;
    assign bus.ddr2_read    = lat_rd;
    assign bus.to_ddr2_data = lat_wdata;
    assign bus.rd_data      = rd_q;

endmodule

// File: tb/tb_ddr2_arbiter.sv
// Self-checking bench for ddr2_arbiter: two requester drivers, a DDR2 model and a scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_ddr2_arbiter;
    import ddr2_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ddr2_arbiter_if bus();
    ddr2_arbiter_if bus5();

    ddr2_arbiter #(.WR_LAT(1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    ddr2_arbiter #(.WR_LAT(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));

    typedef struct {
        bit    wr;
        addr_t addr;
        line_t data;
    } op_t;

    typedef struct {
        bit    wr;
        addr_t line;
        line_t data;   // write data for writes, expected rd_data for reads
    } exp_t;

    op_t   op_q0[$];
    op_t   op_q1[$];
    exp_t  exp_q0[$];
    exp_t  exp_q1[$];
    bit    gnt_q[$];
    line_t ref_mem[addr_t];
    line_t ddr_mem[addr_t];

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    en_cyc = 0;
    int    done_cyc = 0;
    int    load_cyc0 = 0;
    int    n_en = 0;
    bit    active0 = 0, active1 = 0;
    bit    granted0 = 0, granted1 = 0;
    bit    pend = 0;
    int    cnt = 0;
    int    rd_delay = 0;
    addr_t pend_addr = '0;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic line_t def_line(addr_t a);
        return {32'hDEAD_0000, 64'h0, 5'b0, a};
    endfunction

    function automatic line_t ref_rd(addr_t a);
        return ref_mem.exists(a) ? ref_mem[a] : def_line(a);
    endfunction

    function automatic line_t ddr_rd(addr_t a);
        return ddr_mem.exists(a) ? ddr_mem[a] : def_line(a);
    endfunction

    // Queue one request for port p and its expected outcome.
    task automatic enq(bit p, bit wr, addr_t a, line_t d);
        op_t  o;
        exp_t e;
        addr_t la;
        la = a & ~addr_t'(4'hF);
        o.wr = wr; o.addr = a; o.data = d;
        e.wr = wr; e.line = la;
        if (wr) begin
            ref_mem[la] = d;
            e.data = d;
        end else begin
            e.data = ref_rd(la);
        end
        if (p) begin op_q1.push_back(o); exp_q1.push_back(e); end
        else   begin op_q0.push_back(o); exp_q0.push_back(e); end
    endtask

    // One clock: sample at negedge, run scoreboard, DDR2 model and requester drivers.
    task automatic step();
        bit   g;
        exp_t e;
        op_t  o;
        bit   d0, d1;
        @(negedge clk);
        cyc++;
        d0 = bus.done0;
        d1 = bus.done1;
        if (bus.ddr2_enable) begin
            n_en++;
            en_cyc = cyc;
            chk("grant_expected", 128'(gnt_q.size() != 0), 128'(1));
            if (gnt_q.size() != 0) begin
                g = gnt_q.pop_front();
                chk("grant_id", 128'(bus.grant_id), 128'(g));
            end
            if (bus.grant_id) granted1 = 1; else granted0 = 1;
            if ((bus.grant_id ? exp_q1.size() : exp_q0.size()) != 0) begin
                e = bus.grant_id ? exp_q1[0] : exp_q0[0];
                chk("ddr2_addr", 128'(bus.ddr2_addr), 128'(e.line));
                chk("ddr2_read", 128'(bus.ddr2_read), 128'(!e.wr));
                if (e.wr) chk("to_ddr2_data", bus.to_ddr2_data, e.data);
            end
            bus.ddr2_available = 1'b0;
            if (bus.ddr2_read) begin
                pend = 1; cnt = rd_delay; pend_addr = bus.ddr2_addr;
            end else begin
                ddr_mem[bus.ddr2_addr] = bus.to_ddr2_data;
            end
        end else if (pend) begin
            if (cnt == 0) begin
                bus.ddr2_available = 1'b1;
                bus.ddr2_data = ddr_rd(pend_addr);
                pend = 0;
            end else begin
                cnt--;
                bus.ddr2_available = 1'b0;
            end
        end else begin
            bus.ddr2_available = 1'b0;
        end
        if (d0 || d1) begin
            done_cyc = cyc;
            chk("done_exclusive", 128'(d0 && d1), 128'(0));
        end
        if (d0) begin
            chk("done0_expected", 128'(exp_q0.size() != 0), 128'(1));
            if (exp_q0.size() != 0) begin
                e = exp_q0.pop_front();
                if (!e.wr) chk("rd_data0", bus.rd_data, e.data);
            end
            active0 = 0; granted0 = 0;
        end
        if (d1) begin
            chk("done1_expected", 128'(exp_q1.size() != 0), 128'(1));
            if (exp_q1.size() != 0) begin
                e = exp_q1.pop_front();
                if (!e.wr) chk("rd_data1", bus.rd_data, e.data);
            end
            active1 = 0; granted1 = 0;
        end
        // Port 0 requester
        if (!active0 && op_q0.size() != 0) begin
            o = op_q0.pop_front();
            bus.req0 = 1; bus.req0_write = o.wr; bus.req0_addr = o.addr; bus.req0_wdata = o.data;
            active0 = 1; load_cyc0 = cyc;
        end else if (!active0 || granted0) begin
            bus.req0 = active0;
            bus.req0_write = 1'($urandom);
            bus.req0_addr = addr_t'($urandom);
            bus.req0_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
        // Port 1 requester
        if (!active1 && op_q1.size() != 0) begin
            o = op_q1.pop_front();
            bus.req1 = 1; bus.req1_write = o.wr; bus.req1_addr = o.addr; bus.req1_wdata = o.data;
            active1 = 1;
        end else if (!active1 || granted1) begin
            bus.req1 = active1;
            bus.req1_write = 1'($urandom);
            bus.req1_addr = addr_t'($urandom);
            bus.req1_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic drain(string tag, int limit);
        int n = 0;
        while ((op_q0.size() != 0 || op_q1.size() != 0 || active0 || active1 || bus.busy) && n < limit) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, 128'(n < limit), 128'(1));
        chk({tag, "_grants_used"}, 128'(gnt_q.size()), 128'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.ddr2_available = 1'b0;
        pend = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int    e0, n, ens, en_t, dn_t;
        bit    bad;
        line_t w64, w5;
        w64 = 128'h1111_2222_3333_4444_5555_6666_7777_0064;
        w5  = 128'h5555_0000_AAAA_0000_5555_0000_AAAA_0005;
        bus.req0 = 0; bus.req0_write = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1 = 0; bus.req1_write = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
        bus.ddr2_data = '0; bus.ddr2_available = 0;
        bus5.req0 = 0; bus5.req0_write = 0; bus5.req0_addr = '0; bus5.req0_wdata = '0;
        bus5.req1 = 0; bus5.req1_write = 0; bus5.req1_addr = '0; bus5.req1_wdata = '0;
        bus5.ddr2_data = '0; bus5.ddr2_available = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",        128'(bus.busy), 128'(0));
        chk("rst_enable",      128'(bus.ddr2_enable), 128'(0));
        chk("rst_done",        128'({bus.done1, bus.done0}), 128'(0));
        chk("rst_grant_id",    128'(bus.grant_id), 128'(0));
        chk("rst_rd_data",     bus.rd_data, 128'(0));
        chk("rst_ddr2_addr",   128'(bus.ddr2_addr), 128'(0));
        chk("rst_ddr2_read",   128'(bus.ddr2_read), 128'(0));
        chk("rst_to_ddr2",     bus.to_ddr2_data, 128'(0));
        rst_n = 1'b1;

        // Write then read on port 0, same line
        enq(1'b0, 1'b1, 27'd100, w64); gnt_q.push_back(1'b0);
        drain("wr0", 50);
        chk("wr0_enable_lat", 128'(en_cyc - load_cyc0), 128'(1));
        chk("wr0_done_lat",   128'(done_cyc - en_cyc), 128'(2));
        enq(1'b0, 1'b0, 27'd104, '0); gnt_q.push_back(1'b0);
        drain("rd0", 50);
        chk("rd0_enable_lat", 128'(en_cyc - load_cyc0), 128'(1));
        chk("rd0_done_lat",   128'(done_cyc - en_cyc), 128'(2));

        // Simultaneous requests after reset: port 0 wins the tie
        do_reset();
        enq(1'b0, 1'b0, 27'd100, '0);
        enq(1'b1, 1'b0, 27'd16484, '0);
        gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
        drain("tie_a", 50);
        chk("tie_a_last_addr", 128'(bus.ddr2_addr), 128'(27'd16480));
        // One port-0 transaction leaves rr at 1, so the next tie goes to port 1
        enq(1'b0, 1'b0, 27'd200, '0); gnt_q.push_back(1'b0);
        drain("solo", 50);
        enq(1'b0, 1'b0, 27'd100, '0);
        enq(1'b1, 1'b0, 27'd16484, '0);
        gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
        drain("tie_b", 50);

        // Continuous load: grants must alternate
        do_reset();
        enq(1'b0, 1'b1, 27'h1000, 128'hA0A0);
        enq(1'b0, 1'b0, 27'h1008, '0);
        enq(1'b0, 1'b1, 27'h1010, 128'hB0B0);
        enq(1'b1, 1'b1, 27'h2000, 128'hC0C0);
        enq(1'b1, 1'b0, 27'h2004, '0);
        enq(1'b1, 1'b0, 27'h2010, '0);
        enq(1'b1, 1'b1, 27'h2020, 128'hD0D0);
        gnt_q.push_back(1'b0); gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
        gnt_q.push_back(1'b1); gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
        gnt_q.push_back(1'b1);
        drain("load", 200);

        // Slow read: ddr2_available low for 10 cycles after ISSUE
        rd_delay = 10;
        ddr_mem[27'h3000] = 128'hABCD;
        ref_mem[27'h3000] = 128'hABCD;
        enq(1'b0, 1'b0, 27'h3000, '0); gnt_q.push_back(1'b0);
        e0 = n_en; n = 0;
        while (n_en == e0 && n < 10) begin step(); n++; end
        chk("slow_issued", 128'(n_en != e0), 128'(1));
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!bus.busy || bus.done0 || bus.done1) bad = 1;
        end
        chk("slow_waits_busy", 128'(bad), 128'(0));
        drain("slow", 50);
        chk("slow_done_lat", 128'(done_cyc - en_cyc), 128'(12));
        rd_delay = 0;

        // Reset in the middle of a read with port 1 waiting
        rd_delay = 100;
        enq(1'b0, 1'b0, 27'h4000, '0); gnt_q.push_back(1'b0);
        e0 = n_en; n = 0;
        while (n_en == e0 && n < 10) begin step(); n++; end
        chk("mid_issued", 128'(n_en != e0), 128'(1));
        repeat (3) step();
        enq(1'b1, 1'b1, 27'h5000, w5); gnt_q.push_back(1'b1);
        step();
        chk("mid_in_wait_rd", 128'(bus.busy), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",     128'(bus.busy), 128'(0));
        chk("mid_rst_enable",   128'(bus.ddr2_enable), 128'(0));
        chk("mid_rst_done",     128'({bus.done1, bus.done0}), 128'(0));
        chk("mid_rst_rd_data",  bus.rd_data, 128'(0));
        chk("mid_rst_grant_id", 128'(bus.grant_id), 128'(0));
        chk("mid_rst_addr",     128'(bus.ddr2_addr), 128'(0));
        void'(exp_q0.pop_front());
        active0 = 0; granted0 = 0; bus.req0 = 0;
        pend = 0; bus.ddr2_available = 0; rd_delay = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drain("post_rst", 50);

        // Write latency with WR_LAT=5 on the second instance
        @(negedge clk);
        bus5.req0 = 1; bus5.req0_write = 1; bus5.req0_addr = 27'h6004; bus5.req0_wdata = w5;
        ens = 0; en_t = -1; dn_t = -1; bad = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus5.ddr2_enable) begin
                ens++; en_t = k;
                chk("wl5_addr", 128'(bus5.ddr2_addr), 128'(27'h6000));
                chk("wl5_read", 128'(bus5.ddr2_read), 128'(0));
                chk("wl5_wdata", bus5.to_ddr2_data, w5);
            end
            if (bus5.done1) bad = 1;
            if (bus5.done0) begin
                dn_t = k;
                bus5.req0 = 0;
            end
        end
        chk("wl5_enable_at", 128'(en_t), 128'(1));
        chk("wl5_done_at",   128'(dn_t), 128'(7));
        chk("wl5_one_enable", 128'(ens), 128'(1));
        chk("wl5_no_done1",  128'(bad), 128'(0));
        chk("wl5_idle",      128'(bus5.busy), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
